// File: rtl/pipe_id_fwd.sv
// Instruction-decode stage: IF/ID register, register file with WB bypass,
// EXE/MEM/WB operand forwarding, load-use hazard stall and stall counter.
module pipe_id_fwd #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc4,
    input  logic [31:0]       if_inst,
    input  logic              flush,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              exe_rf_w_ena,
    input  logic [REG_AW-1:0] exe_rf_waddr,
    input  logic              exe_is_load,
    input  logic [DATA_W-1:0] exe_result,
    input  logic              mem_rf_w_ena,
    input  logic [REG_AW-1:0] mem_rf_waddr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_rf_w_ena,
    input  logic [REG_AW-1:0] wb_rf_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc4,
    output logic [31:0]       id_inst,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [1:0]        fwd_sel_rs,
    output logic [1:0]        fwd_sel_rt,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int NREG = 2 ** REG_AW;
    localparam bit FWD  = (FWD_EN != 0);

    logic              r_id_valid;
    logic [DATA_W-1:0] r_id_pc4;
    logic [31:0]       r_id_inst;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [DATA_W-1:0] r_rf [NREG];

    // Operand index 0 is rs, 1 is rt.
    logic [REG_AW-1:0] w_addr [2];
    logic [DATA_W-1:0] w_data [2];
    logic [1:0]        w_sel  [2];
    logic [1:0]        w_used;
    logic [1:0]        w_exe_hit;
    logic [1:0]        w_mem_hit;
    logic [1:0]        w_wb_hit;
    logic              w_stall;

    assign w_addr[0] = r_id_inst[21 +: REG_AW];
    assign w_addr[1] = r_id_inst[16 +: REG_AW];
    assign w_used    = {rt_used, rs_used};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic              w_live;
            logic [DATA_W-1:0] w_rf_rd;

            assign w_live        = r_id_valid && w_used[gi] && (w_addr[gi] != '0);
            assign w_exe_hit[gi] = w_live && exe_rf_w_ena && (exe_rf_waddr == w_addr[gi]);
            assign w_mem_hit[gi] = w_live && mem_rf_w_ena && (mem_rf_waddr == w_addr[gi]);
            assign w_wb_hit[gi]  = w_live && wb_rf_w_ena  && (wb_rf_waddr  == w_addr[gi]);
            assign w_rf_rd       = (w_addr[gi] == '0) ? '0 : r_rf[w_addr[gi]];

            // Youngest producer wins; stall-only mode keeps just the WB bypass.
            assign w_sel[gi] = (FWD && w_exe_hit[gi]) ? 2'd1 :
                               (FWD && w_mem_hit[gi]) ? 2'd2 :
                               w_wb_hit[gi]           ? 2'd3 : 2'd0;
            assign w_data[gi] = (w_sel[gi] == 2'd1) ? exe_result :
                                (w_sel[gi] == 2'd2) ? mem_result :
                                (w_sel[gi] == 2'd3) ? wb_wdata   : w_rf_rd;
        end
    endgenerate

    assign w_stall = FWD ? ((w_exe_hit[0] || w_exe_hit[1]) && exe_is_load)
                         : ((w_exe_hit | w_mem_hit) != 2'b00);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rf[gi] <= '0;
                end else if (wb_rf_w_ena && (wb_rf_waddr != '0) &&
                             (wb_rf_waddr == REG_AW'(gi))) begin
                    r_rf[gi] <= wb_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid  <= 1'b0;
            r_id_pc4    <= '0;
            r_id_inst   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_id_valid <= 1'b0;
                r_id_pc4   <= '0;
                r_id_inst  <= '0;
            end else if (!w_stall) begin
                r_id_valid <= if_valid;
                r_id_pc4   <= if_pc4;
                r_id_inst  <= if_inst;
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign id_valid   = r_id_valid;
    assign id_pc4     = r_id_pc4;
    assign id_inst    = r_id_inst;
    assign id_rs_data = w_data[0];
    assign id_rt_data = w_data[1];
    assign fwd_sel_rs = w_sel[0];
    assign fwd_sel_rt = w_sel[1];
    assign stall      = w_stall;
    assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipe_id_fwd.sv
// Directed bench for pipe_id_fwd: forwarding build, stall-only build and a
// narrow-counter build share one stimulus stream.
module tb_pipe_id_fwd;
    logic        clk = 1'b0;
    logic        rst, if_valid, flush, rs_used, rt_used;
    logic [31:0] if_pc4, if_inst;
    logic        exe_rf_w_ena, exe_is_load, mem_rf_w_ena, wb_rf_w_ena;
    logic [4:0]  exe_rf_waddr, mem_rf_waddr, wb_rf_waddr;
    logic [31:0] exe_result, mem_result, wb_wdata;

    logic        a_valid, a_stall, b_valid, b_stall, c_valid, c_stall;
    logic [31:0] a_pc4, a_inst, a_rs, a_rt, b_pc4, b_inst, b_rs, b_rt;
    logic [31:0] c_pc4, c_inst, c_rs, c_rt;
    logic [1:0]  a_sel_rs, a_sel_rt, b_sel_rs, b_sel_rt, c_sel_rs, c_sel_rt;
    logic [31:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_id_fwd #(.FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
        .flush(flush), .rs_used(rs_used), .rt_used(rt_used),
        .exe_rf_w_ena(exe_rf_w_ena), .exe_rf_waddr(exe_rf_waddr), .exe_is_load(exe_is_load),
        .exe_result(exe_result), .mem_rf_w_ena(mem_rf_w_ena), .mem_rf_waddr(mem_rf_waddr),
        .mem_result(mem_result), .wb_rf_w_ena(wb_rf_w_ena), .wb_rf_waddr(wb_rf_waddr),
        .wb_wdata(wb_wdata), .id_valid(a_valid), .id_pc4(a_pc4), .id_inst(a_inst),
        .id_rs_data(a_rs), .id_rt_data(a_rt), .fwd_sel_rs(a_sel_rs), .fwd_sel_rt(a_sel_rt),
        .stall(a_stall), .stall_cnt(a_cnt));

    pipe_id_fwd #(.FWD_EN(0)) dut_nofwd (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
        .flush(flush), .rs_used(rs_used), .rt_used(rt_used),
        .exe_rf_w_ena(exe_rf_w_ena), .exe_rf_waddr(exe_rf_waddr), .exe_is_load(exe_is_load),
        .exe_result(exe_result), .mem_rf_w_ena(mem_rf_w_ena), .mem_rf_waddr(mem_rf_waddr),
        .mem_result(mem_result), .wb_rf_w_ena(wb_rf_w_ena), .wb_rf_waddr(wb_rf_waddr),
        .wb_wdata(wb_wdata), .id_valid(b_valid), .id_pc4(b_pc4), .id_inst(b_inst),
        .id_rs_data(b_rs), .id_rt_data(b_rt), .fwd_sel_rs(b_sel_rs), .fwd_sel_rt(b_sel_rt),
        .stall(b_stall), .stall_cnt(b_cnt));

    pipe_id_fwd #(.FWD_EN(1), .CNT_W(2)) dut_cnt2 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
        .flush(flush), .rs_used(rs_used), .rt_used(rt_used),
        .exe_rf_w_ena(exe_rf_w_ena), .exe_rf_waddr(exe_rf_waddr), .exe_is_load(exe_is_load),
        .exe_result(exe_result), .mem_rf_w_ena(mem_rf_w_ena), .mem_rf_waddr(mem_rf_waddr),
        .mem_result(mem_result), .wb_rf_w_ena(wb_rf_w_ena), .wb_rf_waddr(wb_rf_waddr),
        .wb_wdata(wb_wdata), .id_valid(c_valid), .id_pc4(c_pc4), .id_inst(c_inst),
        .id_rs_data(c_rs), .id_rt_data(c_rt), .fwd_sel_rs(c_sel_rs), .fwd_sel_rt(c_sel_rt),
        .stall(c_stall), .stall_cnt(c_cnt));

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h23, rs, rt, 16'h0042};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards;
        flush = 0; exe_rf_w_ena = 0; exe_is_load = 0; mem_rf_w_ena = 0; wb_rf_w_ena = 0;
        exe_rf_waddr = 0; mem_rf_waddr = 0; wb_rf_waddr = 0;
    endtask

    task automatic do_reset;
        clear_hazards();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic load_inst(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] pc4);
        clear_hazards();
        if_valid = 1; if_inst = mk(rs, rt); if_pc4 = pc4;
        tick();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_rf_w_ena = 1; wb_rf_waddr = a; wb_wdata = d;
        tick();
        wb_rf_w_ena = 0;
    endtask

    task automatic test_reset;
        do_reset();
        wb_write(5'd1, 32'h11); wb_write(5'd2, 32'h22); wb_write(5'd3, 32'h33);
        rs_used = 1; rt_used = 1;
        load_inst(5'd1, 5'd2, 32'h10);
        n_vec++; if (a_rs !== 32'h11) begin n_err++; $display("FAIL pre_rst_r1 got %h want %h", a_rs, 32'h11); end
        n_vec++; if (a_rt !== 32'h22) begin n_err++; $display("FAIL pre_rst_r2 got %h want %h", a_rt, 32'h22); end
        rst = 1; tick(); rst = 0;
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", a_valid); end
        n_vec++; if (a_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h want 0", a_inst); end
        n_vec++; if (a_pc4 !== 32'h0) begin n_err++; $display("FAIL rst_pc4 got %h want 0", a_pc4); end
        n_vec++; if (a_cnt !== 32'h0) begin n_err++; $display("FAIL rst_cnt got %0d want 0", a_cnt); end
        n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", a_stall); end
        n_vec++; if (a_rs !== 32'h0 || a_sel_rs !== 2'd0) begin n_err++; $display("FAIL rst_rs got %h/%0d want 0/0", a_rs, a_sel_rs); end
        load_inst(5'd1, 5'd2, 32'h14);
        n_vec++; if (a_rs !== 32'h0) begin n_err++; $display("FAIL rst_r1 got %h want 0", a_rs); end
        n_vec++; if (a_rt !== 32'h0) begin n_err++; $display("FAIL rst_r2 got %h want 0", a_rt); end
        load_inst(5'd3, 5'd0, 32'h18);
        n_vec++; if (a_rs !== 32'h0) begin n_err++; $display("FAIL rst_r3 got %h want 0", a_rs); end
        $display("test_reset done");
    endtask

    task automatic test_exe_fwd;
        rs_used = 1; rt_used = 0;
        load_inst(5'd5, 5'd6, 32'h20);
        exe_rf_w_ena = 1; exe_rf_waddr = 5'd5; exe_result = 32'h00001234; exe_is_load = 0;
        #1;
        n_vec++; if (a_rs !== 32'h00001234) begin n_err++; $display("FAIL exe_rs got %h want %h", a_rs, 32'h1234); end
        n_vec++; if (a_sel_rs !== 2'd1) begin n_err++; $display("FAIL exe_sel got %0d want 1", a_sel_rs); end
        n_vec++; if (a_sel_rt !== 2'd0) begin n_err++; $display("FAIL exe_sel_rt got %0d want 0", a_sel_rt); end
        n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL exe_stall got %b want 0", a_stall); end
        clear_hazards();
        $display("test_exe_fwd done");
    endtask

    task automatic test_load_use;
        do_reset();
        rs_used = 1; rt_used = 0;
        load_inst(5'd5, 5'd0, 32'h30);
        exe_rf_w_ena = 1; exe_rf_waddr = 5'd5; exe_is_load = 1; exe_result = 32'hDEAD0000;
        if_inst = mk(5'd9, 5'd0); if_pc4 = 32'h34;
        #1;
        n_vec++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %b want 1", a_stall); end
        tick();
        n_vec++; if (a_inst !== mk(5'd5, 5'd0)) begin n_err++; $display("FAIL lu_hold got %h want %h", a_inst, mk(5'd5, 5'd0)); end
        n_vec++; if (a_pc4 !== 32'h30) begin n_err++; $display("FAIL lu_hold_pc got %h want 30", a_pc4); end
        n_vec++; if (a_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt got %0d want 1", a_cnt); end
        exe_rf_w_ena = 0; exe_is_load = 0;
        mem_rf_w_ena = 1; mem_rf_waddr = 5'd5; mem_result = 32'hCAFEF00D;
        #1;
        n_vec++; if (a_rs !== 32'hCAFEF00D) begin n_err++; $display("FAIL lu_mem_rs got %h want cafef00d", a_rs); end
        n_vec++; if (a_sel_rs !== 2'd2) begin n_err++; $display("FAIL lu_mem_sel got %0d want 2", a_sel_rs); end
        n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL lu_mem_stall got %b want 0", a_stall); end
        tick();
        n_vec++; if (a_inst !== mk(5'd9, 5'd0) || a_cnt !== 32'd1) begin n_err++; $display("FAIL lu_advance got %h/%0d want %h/1", a_inst, a_cnt, mk(5'd9, 5'd0)); end
        clear_hazards();
        $display("test_load_use done");
    endtask

    task automatic test_priority;
        rs_used = 1; rt_used = 1;
        load_inst(5'd7, 5'd7, 32'h40);
        exe_rf_w_ena = 1; exe_rf_waddr = 5'd7; exe_result = 32'hA;
        mem_rf_w_ena = 1; mem_rf_waddr = 5'd7; mem_result = 32'hB;
        wb_rf_w_ena  = 1; wb_rf_waddr  = 5'd7; wb_wdata   = 32'hC;
        #1;
        n_vec++; if (a_rs !== 32'hA || a_sel_rs !== 2'd1) begin n_err++; $display("FAIL pri_exe_rs got %h/%0d want a/1", a_rs, a_sel_rs); end
        n_vec++; if (a_rt !== 32'hA || a_sel_rt !== 2'd1) begin n_err++; $display("FAIL pri_exe_rt got %h/%0d want a/1", a_rt, a_sel_rt); end
        exe_rf_w_ena = 0; #1;
        n_vec++; if (a_rs !== 32'hB || a_sel_rs !== 2'd2) begin n_err++; $display("FAIL pri_mem_rs got %h/%0d want b/2", a_rs, a_sel_rs); end
        n_vec++; if (a_rt !== 32'hB || a_sel_rt !== 2'd2) begin n_err++; $display("FAIL pri_mem_rt got %h/%0d want b/2", a_rt, a_sel_rt); end
        mem_rf_w_ena = 0; #1;
        n_vec++; if (a_rs !== 32'hC || a_sel_rs !== 2'd3) begin n_err++; $display("FAIL pri_wb_rs got %h/%0d want c/3", a_rs, a_sel_rs); end
        n_vec++; if (a_rt !== 32'hC || a_sel_rt !== 2'd3) begin n_err++; $display("FAIL pri_wb_rt got %h/%0d want c/3", a_rt, a_sel_rt); end
        n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL pri_stall got %b want 0", a_stall); end
        tick();
        wb_rf_w_ena = 0; #1;
        n_vec++; if (a_rs !== 32'hC || a_sel_rs !== 2'd0) begin n_err++; $display("FAIL pri_rf_rs got %h/%0d want c/0", a_rs, a_sel_rs); end
        clear_hazards();
        $display("test_priority done");
    endtask

    task automatic test_r0_unused;
        rs_used = 1; rt_used = 0;
        load_inst(5'd0, 5'd4, 32'h50);
        exe_rf_w_ena = 1; exe_rf_waddr = 5'd0; exe_result = 32'hFFFFFFFF; exe_is_load = 1;
        #1;
        n_vec++; if (a_rs !== 32'h0 || a_sel_rs !== 2'd0) begin n_err++; $display("FAIL r0_rs got %h/%0d want 0/0", a_rs, a_sel_rs); end
        n_vec++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL r0_stall got %b want 0", a_stall); end
        exe_rf_waddr = 5'd4; #1;
        n_vec++; if (a_stall !== 1'b0 || a_sel_rt !== 2'd0) begin n_err++; $display("FAIL unused_rt got %b/%0d want 0/0", a_stall, a_sel_rt); end
        rt_used = 1; #1;
        n_vec++; if (a_stall !== 1'b1 || a_sel_rt !== 2'd1) begin n_err++; $display("FAIL used_rt got %b/%0d want 1/1", a_stall, a_sel_rt); end
        clear_hazards();
        $display("test_r0_unused done");
    endtask

    task automatic test_saturate;
        do_reset();
        rs_used = 1; rt_used = 0;
        load_inst(5'd5, 5'd0, 32'h60);
        exe_rf_w_ena = 1; exe_rf_waddr = 5'd5; exe_is_load = 1;
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (a_cnt !== 32'd5) begin n_err++; $display("FAIL cnt32 got %0d want 5", a_cnt); end
        n_vec++; if (c_cnt !== 2'd3) begin n_err++; $display("FAIL cnt2_sat got %0d want 3", c_cnt); end
        clear_hazards();
        $display("test_saturate done");
    endtask

    task automatic test_nofwd;
        do_reset();
        rs_used = 1; rt_used = 0;
        load_inst(5'd3, 5'd0, 32'h100);
        mem_rf_w_ena = 1; mem_rf_waddr = 5'd3; mem_result = 32'h77;
        #1;
        n_vec++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL nf_stall got %b want 1", b_stall); end
        n_vec++; if (a_stall !== 1'b0 || a_sel_rs !== 2'd2) begin n_err++; $display("FAIL fwd_mem got %b/%0d want 0/2", a_stall, a_sel_rs); end
        n_vec++; if (b_sel_rs !== 2'd0) begin n_err++; $display("FAIL nf_sel_stall got %0d want 0", b_sel_rs); end
        tick();
        n_vec++; if (b_cnt !== 32'd1) begin n_err++; $display("FAIL nf_cnt got %0d want 1", b_cnt); end
        mem_rf_w_ena = 0;
        wb_rf_w_ena = 1; wb_rf_waddr = 5'd3; wb_wdata = 32'h55;
        #1;
        n_vec++; if (b_rs !== 32'h55 || b_sel_rs !== 2'd3) begin n_err++; $display("FAIL nf_wb got %h/%0d want 55/3", b_rs, b_sel_rs); end
        n_vec++; if (b_stall !== 1'b0) begin n_err++; $display("FAIL nf_wb_stall got %b want 0", b_stall); end
        tick();
        wb_rf_w_ena = 0;
        mem_rf_w_ena = 1; mem_rf_waddr = 5'd3;
        #1;
        n_vec++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL nf_stall2 got %b want 1", b_stall); end
        flush = 1;
        tick();
        flush = 0;
        n_vec++; if (b_valid !== 1'b0 || b_inst !== 32'h0 || b_pc4 !== 32'h0) begin n_err++; $display("FAIL nf_flush got %b/%h/%h want 0/0/0", b_valid, b_inst, b_pc4); end
        n_vec++; if (b_cnt !== 32'd2) begin n_err++; $display("FAIL nf_cnt2 got %0d want 2", b_cnt); end
        n_vec++; if (b_stall !== 1'b0) begin n_err++; $display("FAIL nf_bubble_stall got %b want 0", b_stall); end
        clear_hazards();
        $display("test_nofwd done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; if_valid = 0; if_pc4 = 0; if_inst = 0; rs_used = 0; rt_used = 0;
        exe_result = 0; mem_result = 0; wb_wdata = 0;
        clear_hazards();
        tick(); tick();
        test_reset();
        test_exe_fwd();
        test_load_use();
        test_priority();
        test_r0_unused();
        test_saturate();
        test_nofwd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
